// File: rtl/fixedpoint_accum.sv
// Saturating frame accumulator for unsigned 6.2 products.
// Beats are summed into an ACC_W-wide 2-fraction-bit accumulator. A frame
// closes on in_last or after MAX_LEN beats. The total, beat count and a
// sticky overflow flag are then held on a valid/ready output until taken.
module fixedpoint_accum #(
    parameter int ACC_W   = 12,
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

    state_t           state, state_next;
    logic [ACC_W-1:0] acc, acc_next;
    logic [CNT_W-1:0] count, count_next;
    logic             ovf, ovf_next;

    logic             accept;
    logic [ACC_W:0]   sum_wide;
    logic [CNT_W-1:0] count_inc;

    // Every output comes from a register or the state decode.
    // There is no input-to-output combinational path.
    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign out_sum   = acc;
    assign out_count = count;
    assign out_ovf   = ovf;

    assign accept    = in_valid && in_ready;
    // One extra bit holds the carry, so overflow is just the MSB.
    assign sum_wide  = {1'b0, acc} + (ACC_W + 1)'(in_data);
    assign count_inc = count + CNT_W'(1);

    // Next-state and datapath update for the IDLE/ACC/DONE frame FSM.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves a signal unassigned (which would infer a latch).
        state_next = state;
        acc_next   = acc;
        count_next = count;
        ovf_next   = ovf;
        case (state)
            IDLE: begin
                if (accept) begin
                    acc_next   = ACC_W'(in_data);
                    count_next = CNT_W'(1);
                    ovf_next   = 1'b0;
                    state_next = (in_last || MAX_LEN == 1) ? DONE : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    if (sum_wide[ACC_W]) begin
                        // Clamp. Unsigned beats can never bring acc back down.
                        acc_next = '1;
                        ovf_next = 1'b1;
                    end else begin
                        acc_next = sum_wide[ACC_W-1:0];
                    end
                    count_next = count_inc;
                    state_next = (in_last || count_inc == MAX_CNT) ? DONE : ACC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                    acc_next   = '0;
                    count_next = '0;
                    ovf_next   = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers. Reset drops any partial or unread frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // register samples pre-edge values no matter the statement order.
            state <= state_next;
            acc   <= acc_next;
            count <= count_next;
            ovf   <= ovf_next;
        end
    end

endmodule

// File: tb/tb_fixedpoint_accum.sv
// Bench for fixedpoint_accum. Identical stimulus drives a 12-bit and a 9-bit
// accumulator instance, so saturation and non-saturation are checked together.
module tb_fixedpoint_accum;

    localparam int BOUND = 50;

    typedef struct {
        logic [11:0] sum12;
        logic        ovf12;
        logic [8:0]  sum9;
        logic        ovf9;
        logic [4:0]  count;
    } exp_t;

    typedef struct {
        int         n;
        logic       last;
        logic [7:0] beat [16];
        exp_t       exp;
    } frame_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_ready;

    logic        ready12, valid12, ovf12;
    logic [11:0] sum12;
    logic [4:0]  count12;
    logic        ready9, valid9, ovf9;
    logic [8:0]  sum9;
    logic [4:0]  count9;

    int     n_checks = 0;
    int     n_fail   = 0;
    exp_t   q [$];
    exp_t   mon_e;
    frame_t frames [8];

    fixedpoint_accum #(.ACC_W(12), .MAX_LEN(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(ready12), .in_data(in_data), .in_last(in_last),
        .out_valid(valid12), .out_ready(out_ready),
        .out_sum(sum12), .out_count(count12), .out_ovf(ovf12)
    );

    fixedpoint_accum #(.ACC_W(9), .MAX_LEN(16)) dut9 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(ready9), .in_data(in_data), .in_last(in_last),
        .out_valid(valid9), .out_ready(out_ready),
        .out_sum(sum9), .out_count(count9), .out_ovf(ovf9)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Pops and compares one expected record per completed output handshake.
    always @(negedge clk) begin
        if (rst_n && valid12 && out_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_frame: got sum 0x%0h count %0d required no frame", sum12, count12);
            end else begin
                mon_e = q.pop_front();
                check("frame_sum12",  32'(sum12),   32'(mon_e.sum12));
                check("frame_ovf12",  32'(ovf12),   32'(mon_e.ovf12));
                check("frame_count",  32'(count12), 32'(mon_e.count));
                check("frame_valid9", 32'(valid9),  32'd1);
                check("frame_sum9",   32'(sum9),    32'(mon_e.sum9));
                check("frame_ovf9",   32'(ovf9),    32'(mon_e.ovf9));
                check("frame_count9", 32'(count9),  32'(mon_e.count));
            end
        end
    end

    task automatic set_frame(input int k, input int n, input logic last, input logic [7:0] v,
                             input logic [11:0] s12, input logic o12,
                             input logic [8:0] s9, input logic o9, input logic [4:0] c);
        frames[k].n    = n;
        frames[k].last = last;
        for (int i = 0; i < 16; i++) frames[k].beat[i] = v;
        frames[k].exp.sum12 = s12;
        frames[k].exp.ovf12 = o12;
        frames[k].exp.sum9  = s9;
        frames[k].exp.ovf9  = o9;
        frames[k].exp.count = c;
    endtask

    function automatic exp_t mk(input logic [11:0] s12, input logic o12,
                                input logic [8:0] s9, input logic o9, input logic [4:0] c);
        exp_t e;
        e.sum12 = s12; e.ovf12 = o12; e.sum9 = s9; e.ovf9 = o9; e.count = c;
        return e;
    endfunction

    // Presents a beat and holds it until it is accepted. Returns on the
    // falling edge just before the accepting rising edge.
    task automatic drive_beat(input logic [7:0] d, input logic last);
        int waited = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        forever begin
            @(negedge clk);
            if (ready12) break;
            waited++;
            if (waited >= BOUND) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: got no accept in %0d cycles required accept", waited);
                break;
            end
        end
    endtask

    // Checks that DONE follows the last accept by one edge. A beat held on the
    // input during DONE must be refused.
    task automatic finish_frame(input string tag);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        in_last  = 1'b0;
        @(negedge clk);
        check({tag, "_done_valid"}, 32'(valid12), 32'd1);
        check({tag, "_done_ready"}, 32'(ready12), 32'd0);
        check({tag, "_done_ready9"}, 32'(ready9), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input int k);
        q.push_back(frames[k].exp);
        for (int i = 0; i < frames[k].n; i++)
            drive_beat(frames[k].beat[i], frames[k].last && (i == frames[k].n - 1));
        finish_frame($sformatf("frame%0d", k));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(valid12), 32'd0);
        check({tag, "_sum"},   32'(sum12),   32'd0);
        check({tag, "_count"}, 32'(count12), 32'd0);
        check({tag, "_ovf"},   32'(ovf12),   32'd0);
        check({tag, "_ready"}, 32'(ready12), 32'd1);
        check({tag, "_sum9"},  32'(sum9),    32'd0);
    endtask

    initial begin
        //           k  n   last  beat   sum12   o12   sum9     o9    cnt
        set_frame(0, 3,  1'b1, 8'h00, 12'h012, 1'b0, 9'h012, 1'b0, 5'd3);
        frames[0].beat[0] = 8'h05;
        frames[0].beat[1] = 8'h0A;
        frames[0].beat[2] = 8'h03;
        set_frame(1, 3,  1'b1, 8'hFF, 12'h2FD, 1'b0, 9'h1FF, 1'b1, 5'd3);
        set_frame(2, 16, 1'b0, 8'h01, 12'h010, 1'b0, 9'h010, 1'b0, 5'd16);
        set_frame(3, 1,  1'b1, 8'h7F, 12'h07F, 1'b0, 9'h07F, 1'b0, 5'd1);
        set_frame(4, 4,  1'b1, 8'h80, 12'h200, 1'b0, 9'h1FF, 1'b1, 5'd4);
        set_frame(5, 16, 1'b0, 8'hFF, 12'hFF0, 1'b0, 9'h1FF, 1'b1, 5'd16);
        set_frame(6, 2,  1'b1, 8'h00, 12'h000, 1'b0, 9'h000, 1'b0, 5'd2);
        set_frame(7, 16, 1'b1, 8'h02, 12'h020, 1'b0, 9'h020, 1'b0, 5'd16);

        // Hold reset with a valid beat present. Nothing may be accepted.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        in_last   = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1 rst_n = 1'b1;

        for (int k = 0; k < 8; k++) run_frame(k);

        // in_last with in_valid low must not end the frame.
        q.push_back(mk(12'h005, 1'b0, 9'h005, 1'b0, 5'd2));
        drive_beat(8'h02, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b1;
        drive_beat(8'h03, 1'b1);
        finish_frame("gap_last");

        // Backpressure: the result is held while a new beat waits at the input.
        out_ready = 1'b0;
        q.push_back(mk(12'h00C, 1'b0, 9'h00C, 1'b0, 5'd2));
        drive_beat(8'h04, 1'b0);
        drive_beat(8'h08, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 8'h20;
        in_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", 32'(valid12), 32'd1);
            check("bp_sum",   32'(sum12),   32'h00C);
            check("bp_count", 32'(count12), 32'd2);
            check("bp_ready", 32'(ready12), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        q.push_back(mk(12'h021, 1'b0, 9'h021, 1'b0, 5'd2));
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_release_valid", 32'(valid12), 32'd0);
        check("bp_release_ready", 32'(ready12), 32'd1);
        @(posedge clk); #1;
        in_data   = 8'h01;
        in_last   = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_second_ready", 32'(ready12), 32'd1);
        finish_frame("bp_next");

        // Asynchronous reset in mid-frame discards the partial sum.
        drive_beat(8'hFF, 1'b0);
        drive_beat(8'hFF, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_zero("rst_mid");
        #1 rst_n = 1'b1;
        q.push_back(mk(12'h003, 1'b0, 9'h003, 1'b0, 5'd1));
        drive_beat(8'h03, 1'b1);
        finish_frame("after_rst_mid");

        // Asynchronous reset while a result waits in DONE.
        out_ready = 1'b0;
        drive_beat(8'h10, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_done_reached", 32'(valid12), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_zero("rst_done");
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        q.push_back(mk(12'h005, 1'b0, 9'h005, 1'b0, 5'd1));
        drive_beat(8'h05, 1'b1);
        finish_frame("after_rst_done");

        for (int c = 0; c < 20 && q.size() != 0; c++) @(negedge clk);
        check("scoreboard_drain", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
